multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder in the 16-bit ARM core.
- Sequences each instruction through fetch, decode, execute, memory and writeback states over a shared memory port with a ready handshake.
- Parametrised in opcode width and wait-timeout depth; traps on illegal opcodes and memory timeouts.
- Counts retired instructions. Sits between the instruction register/datapath and the unified memory interface.

Parameters:
- OP_W, 2, opcode width; codes >= 4 are illegal.
- WAIT_MAX, 15, max cycles a memory state waits for mem_ready before timeout trap (>=1).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; sampled only in IDLE
- op  in  OP_W  opcode from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- iord  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load instruction register
- pc_write  out  1  PC update (PC+2 or branch target)
- pc_src  out  1  0 = PC+2, 1 = branch target
- reg_write  out  1  register file write
- mem_write  out  1  memory write qualifier
- res_src  out  1  writeback select: 0 = ALU, 1 = memory
- alu_src  out  1  0 = register, 1 = immediate
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded
- illegal  out  1  sticky illegal-opcode flag
- timeout  out  1  sticky memory-timeout flag
- retired  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, WB_ALU, MEM_ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, TRAP.
- State is registered. Control outputs are Moore decodes of the state. Any output not listed for a state is 0.
- Reset (async, any time, including mid-memory-wait): state = IDLE; all outputs 0; wait counter, op_q and retired = 0; illegal and timeout = 0.
- IDLE: if en, go to FETCH next cycle; otherwise stay.
- FETCH: mem_req=1, iord=0. When mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE.
- DECODE: latch op into op_q.
  - 00 -> EXEC_R
  - 01 or 11 -> MEM_ADDR
  - 10 -> BRANCH
  - other -> TRAP, set illegal
- EXEC_R: alu_src=0, alu_op=10 -> WB_ALU.
- WB_ALU: reg_write=1, res_src=0 -> FETCH.
- MEM_ADDR: alu_src=1, alu_op=00. op_q=01 -> MEM_RD; op_q=11 -> MEM_WR.
- MEM_RD: mem_req=1, iord=1. When mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, res_src=1 -> FETCH.
- MEM_WR: mem_req=1, iord=1, mem_write=1. When mem_ready -> FETCH.
- BRANCH: alu_src=0, alu_op=01, pc_src=1, pc_write=zero -> FETCH.
- Latency with mem_ready held high: R-type 4, load 5, store 4, branch 3 cycles. Each cycle mem_ready is low adds 1.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - When it would reach WAIT_MAX with mem_ready=0 -> TRAP, set timeout. No ir_write, pc_write or reg_write is issued.
  - mem_ready in the same cycle the limit hits takes priority; no trap.
- TRAP: all control outputs 0, mem_req=0. Held until reset. illegal and timeout stay sticky.
- retired increments by 1 on the cycle leaving WB_ALU, WB_MEM, MEM_WR (with mem_ready) or BRANCH. Wraps modulo 2^CNT_W. Trapped instructions are not counted.
- en is ignored outside IDLE.
- op changing after DECODE has no effect; op_q governs.
- mem_write is never asserted without mem_req.
- reg_write and mem_write are never both 1 in the same cycle.

Test Plan:
- Reset then en=1, op=00, mem_ready=1 -> IDLE, FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 only in WB_ALU with res_src=0; retired=1 after 4 cycles.
- op=01, mem_ready low 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles; WB_MEM asserts reg_write=1, res_src=1; total 8 cycles.
- op=10 with zero=1, then zero=0 -> pc_write=1, pc_src=1 in BRANCH for the first; pc_write=0 for the second; both counted in retired.
- OP_W=3, op=3'b101 -> DECODE goes to TRAP; illegal=1; all controls 0 for 10 cycles; retired unchanged.
- WAIT_MAX=4, mem_ready=0 in FETCH -> TRAP after 4 cycles, timeout=1, ir_write never 1. Repeat with mem_ready rising on the 4th cycle -> no trap.
- Assert rst_n low mid-MEM_WR -> outputs 0 immediately (async), flags and retired cleared. CNT_W=2 run 5 instructions -> retired=1 (wrap).

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences fetch/decode/execute/memory/writeback
// over a shared ready-handshaked memory port, with illegal/timeout traps.
// Ports: clk, rst_n (async low); en, op, zero, mem_ready in;
//   mem_req, iord, ir_write, pc_write, pc_src, reg_write, mem_write,
//   res_src, alu_src, alu_op control out; illegal, timeout, retired status.
module multicycle_control_fsm #(
  parameter int OP_W     = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             res_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WLIM = WW'(WAIT_MAX - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU,
    S_MEM_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR,
    S_BRANCH, S_TRAP
  } state_e;

  state_e           state_q, state_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic [1:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic [31:0] op_w;
  logic        op_ok;
  logic        wait_hit;
  logic        waiting;

  assign illegal = ill_q;
  assign timeout = to_q;
  assign retired = ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    op_d      = op_q;
    ill_d     = ill_q;
    to_d      = to_q;
    ret_d     = ret_q;
    mem_req   = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    res_src   = 1'b0;
    alu_src   = 1'b0;
    alu_op    = 2'b00;
    op_w      = 32'(op);
    op_ok     = op_w < 32'd4;
    // Last permitted idle cycle with memory still not ready.
    wait_hit  = (wcnt_q == WLIM) && !mem_ready;
    waiting   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en) state_d = S_FETCH;
      end
      S_FETCH: begin
        waiting = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_hit) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        op_d = op[1:0];
        if (!op_ok) begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end else begin
          unique case (op[1:0])
            2'b00:   state_d = S_EXEC_R;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_MEM_ADDR;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_op  = 2'b10;
        state_d = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        ret_d     = ret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src = 1'b1;
        state_d = (op_q == 2'b11) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        waiting = 1'b1;
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (wait_hit) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        res_src   = 1'b1;
        ret_d     = ret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_MEM_WR: begin
        waiting   = 1'b1;
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          ret_d   = ret_q + CNT_W'(1);
          state_d = S_FETCH;
        end else if (wait_hit) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_BRANCH: begin
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = zero;
        ret_d    = ret_q + CNT_W'(1);
        state_d  = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Any state change restarts the wait count for the next memory state.
    if (state_d != state_q) begin
      wcnt_d = '0;
    end else if (waiting && !mem_ready) begin
      wcnt_d = wcnt_q + WW'(1);
    end
  end

endmodule
